// File: rtl/fpmul_share_arb_pkg.sv
// Shared types and constants for the FP multiplier share arbiter.
// Inflight entries carry a tag field sized for the widest tag any instance may use.
package fpmul_share_arb_pkg;

  localparam int unsigned FP33_W   = 33;
  localparam int unsigned RAISE_W  = 11;
  localparam int unsigned RMODE_W  = 3;
  localparam int unsigned PORT_W   = 3;
  localparam int unsigned TAGW_MAX = 16;

  typedef enum logic [RMODE_W-1:0] {
    TRUNC = 3'd0,
    ROUND = 3'd1,
    EVEN  = 3'd2,
    PLUS  = 3'd3,
    MINUS = 3'd4,
    UP    = 3'd5,
    DOWN  = 3'd6
  } rmode_e;

  typedef struct packed {
    logic                vld;
    logic [PORT_W-1:0]   port;
    logic [TAGW_MAX-1:0] tag;
  } inflight_t;

  // Next round-robin start position after a grant to port g among n ports.
  function automatic logic [PORT_W-1:0] rr_next(input logic [PORT_W-1:0] g,
                                                input int unsigned     n);
    return (32'(g) + 32'd1 >= n) ? '0 : g + PORT_W'(1);
  endfunction

endpackage

// File: rtl/fpmul_share_arb_if.sv
// Requester-side bus of the FP multiplier share arbiter: per-port operands, tag and grant.
interface fpmul_share_arb_if
  import fpmul_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 6
);

  logic [NREQ-1:0]         req_vld;
  logic [NREQ*FP33_W-1:0]  req_A;
  logic [NREQ*FP33_W-1:0]  req_B;
  logic [NREQ-1:0]         req_copyA;
  logic [NREQ*RMODE_W-1:0] req_rmode;
  logic [NREQ*TAGW-1:0]    req_tag;
  logic [NREQ-1:0]         req_rdy;

  modport master (
    output req_vld, req_A, req_B, req_copyA, req_rmode, req_tag,
    input  req_rdy
  );

  modport slave (
    input  req_vld, req_A, req_B, req_copyA, req_rmode, req_tag,
    output req_rdy
  );

endinterface

// File: rtl/fpmul_share_arb_rr_pick.sv
// Round-robin one-hot picker: first requester at or above ptr wins, wrapping to the bottom.
module fpmul_share_arb_rr_pick
  import fpmul_share_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      req,
  input  logic [PORT_W-1:0] ptr,
  output logic [N-1:0]      gnt,
  output logic [PORT_W-1:0] idx,
  output logic              any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] src;

  // Requests at or above ptr take priority; only if none exist do the lower ones compete.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      upper_mask[i] = (i >= 32'(ptr));
    end
    req_hi = req & upper_mask;
    src    = (|req_hi) ? req_hi : req;
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && src[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = PORT_W'(i);
      end
    end
  end

endmodule

// File: rtl/fpmul_share_arb.sv
// Shares one fixed-latency FP multiplier among NREQ requesters and routes results back by port/tag.
// Optional sticky exception accumulator enabled by defining FPMUL_ARB_STICKY_EN.
module fpmul_share_arb
  import fpmul_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned TAGW = 6
) (
  input  logic               clk,
  input  logic               rst,
  fpmul_share_arb_if.slave   req_bus,
  input  logic               hold,
  input  logic               flush,
  output logic [FP33_W-1:0]  mul_A,
  output logic [FP33_W-1:0]  mul_B,
  output logic               mul_copyA,
  output logic [RMODE_W-1:0] mul_rmode,
  output logic               mul_en,
  input  logic [FP33_W-1:0]  mul_res,
  input  logic [RAISE_W-1:0] mul_raise,
  output logic               out_vld,
  output logic [PORT_W-1:0]  out_port,
  output logic [TAGW-1:0]    out_tag,
  output logic [FP33_W-1:0]  out_res,
  output logic [RAISE_W-1:0] out_raise
`ifdef FPMUL_ARB_STICKY_EN
  ,
  output logic [RAISE_W-1:0] raise_acc,
  input  logic               raise_clr
`endif
);

  logic [PORT_W-1:0] ptr_q;
  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   gnt;
  logic [PORT_W-1:0] gnt_idx;
  logic              gnt_any;
  logic [TAGW-1:0]   gnt_tag;
  inflight_t         pipe_q [LAT];
  logic              unused_tag_hi;

  // Reset behaves like flush: no new issue while either is active.
  assign cand = (rst || hold || flush) ? '0 : req_bus.req_vld;

  fpmul_share_arb_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req (cand),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_bus.req_rdy = gnt;
  assign mul_en          = gnt_any;

  always_comb begin
    mul_A     = '0;
    mul_B     = '0;
    mul_copyA = 1'b0;
    mul_rmode = '0;
    gnt_tag   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mul_A     = req_bus.req_A[FP33_W*i +: FP33_W];
        mul_B     = req_bus.req_B[FP33_W*i +: FP33_W];
        mul_copyA = req_bus.req_copyA[i];
        mul_rmode = req_bus.req_rmode[RMODE_W*i +: RMODE_W];
        gnt_tag   = req_bus.req_tag[TAGW*i +: TAGW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= rr_next(gnt_idx, NREQ);
    end
  end

  // Tracking pipe mirrors the multiplier latency; it never stalls, only flushes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= '{vld: gnt_any, port: gnt_idx, tag: TAGW_MAX'(gnt_tag)};
      for (int unsigned k = 1; k < LAT; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign out_vld       = pipe_q[LAT-1].vld & ~flush & ~rst;
  assign out_port      = pipe_q[LAT-1].port;
  assign out_tag       = pipe_q[LAT-1].tag[TAGW-1:0];
  assign out_res       = mul_res;
  assign out_raise     = mul_raise;
  assign unused_tag_hi = ^pipe_q[LAT-1].tag;

`ifdef FPMUL_ARB_STICKY_EN
  // Clear takes effect before the OR, so a same-cycle result survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      raise_acc <= '0;
    end else begin
      raise_acc <= (raise_clr ? '0 : raise_acc) | (out_vld ? out_raise : '0);
    end
  end
`endif

endmodule

// File: doc/fpmul_share_arb.md
Name: fpmul_share_arb

Overview:
- Shares one single-precision FP multiplier (33-bit internal format, fixed pipeline latency) between NREQ requesters.
- Each cycle, picks at most one request by round-robin and drives the multiplier operand, rounding-mode and enable inputs.
- Tracks each in-flight operation with a tag/port shift register and returns the result and exception flags to the issuing requester exactly LAT cycles later.
- Sits between the FP issue queues and the multiplier instance in the FPU cluster.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, multiplier latency in cycles, from enable-cycle to result-cycle.
- TAGW, 6, width of the requester-supplied tag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_vld  in  NREQ  request valid per port.
- req_A  in  NREQ*33  operand A per port, port i at [33*i+:33].
- req_B  in  NREQ*33  operand B per port.
- req_copyA  in  NREQ  pass A through unchanged.
- req_rmode  in  NREQ*3  rounding mode per port.
- req_tag  in  NREQ*TAGW  destination tag per port.
- req_rdy  out  NREQ  one-hot grant; request accepted this cycle.
- hold  in  1  block all new issue (fpcsr update in progress).
- flush  in  1  kill all in-flight operations.
- mul_A, mul_B  out  33  operands to the multiplier.
- mul_copyA  out  1  copyA to the multiplier.
- mul_rmode  out  3  rounding mode to the multiplier.
- mul_en  out  1  multiplier enable.
- mul_res  in  33  multiplier result.
- mul_raise  in  11  multiplier exception flags.
- out_vld  out  1  result valid.
- out_port  out  3  index of the requester that issued the returning operation.
- out_tag  out  TAGW  returned tag.
- out_res  out  33  result (equals mul_res).
- out_raise  out  11  flags (equal mul_raise).

Behaviour:
- Reset:
  - rr pointer is 0.
  - All LAT shift-register valid bits are 0.
  - out_vld is 0; req_rdy is 0; mul_en is 0.
  - All data outputs are don't-care, driven 0.
- Arbitration is combinational:
  - Grant goes to the first req_vld[i] searching from ptr upward, modulo NREQ.
  - req_rdy is one-hot or zero.
  - No grant while hold or flush is high.
- Handshake:
  - A requester holds its valid and payload stable until req_rdy.
  - Transfer happens on req_vld & req_rdy in the same cycle.
  - No skid buffering.
- Issue cycle t:
  - mul_A, mul_B, mul_copyA and mul_rmode are muxed from the granted port; mul_en = 1.
  - With no grant, mul_en = 0 and the data outputs are 0.
- Pointer update:
  - On a grant to port g, ptr <= (g+1) mod NREQ.
  - With no grant, ptr holds.
- Tracking:
  - Stage 0 captures {vld = grant, port, tag} at the end of cycle t.
  - The stages shift every cycle; there is no stall.
  - At stage LAT-1 the entry is visible combinationally in cycle t+LAT.
  - out_vld, out_port and out_tag come from that stage; out_res and out_raise are mul_res and mul_raise in the same cycle.
- Throughput is one issue per cycle, so back-to-back grants give back-to-back results.
- Flush:
  - Clears every valid bit synchronously, and out_vld is forced 0 in the flush cycle.
  - Results from the multiplier in later cycles are ignored, because their valid bits are gone.
- Flush and grant in the same cycle: the grant is suppressed, so nothing is issued.
- rst mid-operation behaves identically to flush and also resets ptr.
- Output has no backpressure; consumers must always accept out_vld.

Optional Feature:
- Macro: FPMUL_ARB_STICKY_EN.
- With the macro defined:
  - Add ports raise_acc (out, 11) and raise_clr (in, 1).
  - raise_acc <= (raise_clr ? 0 : raise_acc) | (out_vld ? out_raise : 0), so clear and set in the same cycle leaves only the new flags.
  - raise_acc resets to 0.
- Without the macro: neither port exists and no sticky logic is present.

Decomposition:
- Shared package:
  - FP33_W = 33, RAISE_W = 11, RMODE_W = 3.
  - Rounding-mode constants: TRUNC = 0, ROUND = 1, EVEN = 2, PLUS = 3, MINUS = 4, UP = 5, DOWN = 6.
  - Inflight entry typedef {vld, port[2:0], tag}.
- One natural sub-module: rr_pick, a parameterised round-robin one-hot picker with pointer input and encoded-index output.

Test Plan:
- Reset, then req_vld = 4'b0001 with A = 0x0_3f800000 (1.0) and B = 0x0_40000000 (2.0): req_rdy = 0001 and mul_en = 1 in cycle t; out_vld = 1, out_port = 0 and out_tag echoed at t+2.
- All four ports valid continuously for 8 cycles from ptr 0: grants 0,1,2,3,0,1,2,3; out_port follows the same sequence two cycles later.
- Issue in cycles t and t+1, flush at t+1: no grant at t+1; out_vld = 0 at t+1, t+2 and t+3.
- hold high for 3 cycles while port 2 is valid: req_rdy = 0 and mul_en = 0 throughout; grant to port 2 in the first cycle after hold drops; ptr becomes 3.
- With FPMUL_ARB_STICKY_EN: return raise = 0x001 then 0x100, pulse raise_clr together with a third result raise 0x004: raise_acc goes 0x001, 0x101, then 0x004.
- rst asserted with 2 in flight: out_vld stays 0 for the next 2 cycles; the next grant goes to the lowest valid port.
